// File: rtl/rw_issuer.sv
// rw_issuer: arbitrates single-entry write/read holding registers onto one memory command port,
// round-robin on contention, with a fixed-latency read response and a saturating conflict counter.
module rw_issuer #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          wr_en,
  output logic          rd_en,
  output logic          valid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rd_rsp_valid,
  output logic [DW-1:0] rd_rsp_data,
  output logic [3:0]    conflict_cnt,
  output logic          limit_hit
);
  typedef enum logic [1:0] {IDLE, WR, RD, RDLAT} state_t;
  state_t        r_state, w_next;
  logic          r_live, r_wr_full, r_rd_full, r_rr, r_rsp_valid;
  logic [AW-1:0] r_wr_addr, r_rd_addr;
  logic [DW-1:0] r_wr_data, r_rsp_data;
  logic [3:0]    r_cnt;
  logic          w_wr_acc, w_rd_acc, w_any, w_both, w_grant_wr;
  // r_live keeps both readys low until the first edge after reset release
  assign wr_req_ready = r_live & ~r_wr_full;
  assign rd_req_ready = r_live & ~r_rd_full;
  assign w_wr_acc     = wr_req_valid & wr_req_ready;
  assign w_rd_acc     = rd_req_valid & rd_req_ready;
  assign w_any        = r_wr_full | r_rd_full;
  assign w_both       = r_wr_full & r_rd_full;
  assign w_grant_wr   = r_wr_full & (~r_rd_full | ~r_rr);
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_any ? (w_grant_wr ? WR : RD) : IDLE;
      RD:      w_next = RDLAT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_live      <= 1'b0;
      r_wr_full   <= 1'b0;
      r_rd_full   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_addr   <= '0;
      r_rr        <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_wr_acc) begin
        r_wr_full <= 1'b1;
        r_wr_addr <= wr_addr;
        r_wr_data <= wr_data;
      end else if (r_state == WR) r_wr_full <= 1'b0;
      if (w_rd_acc) begin
        r_rd_full <= 1'b1;
        r_rd_addr <= rd_addr;
      end else if (r_state == RD) r_rd_full <= 1'b0;
      // after a write grant favour reads, after a read grant favour writes
      if (r_state == IDLE && w_any) r_rr <= w_grant_wr;
      if (r_state == IDLE && w_both && r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
      r_rsp_valid <= (r_state == RDLAT);
      if (r_state == RDLAT) r_rsp_data <= mem_rdata;
    end
  end
  assign wr_en        = (r_state == WR);
  assign rd_en        = (r_state == RD);
  assign valid        = wr_en | rd_en;
  assign mem_addr     = wr_en ? r_wr_addr : rd_en ? r_rd_addr : '0;
  assign mem_wdata    = wr_en ? r_wr_data : '0;
  assign rd_rsp_valid = r_rsp_valid;
  assign rd_rsp_data  = r_rsp_data;
  assign conflict_cnt = r_cnt;
  assign limit_hit    = (r_cnt >= 4'd14);
endmodule

// File: tb/tb_rw_issuer.sv
// tb_rw_issuer: scoreboard bench; stimulus pushes expected commands/responses, a negedge monitor pops and checks.
module tb_rw_issuer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_req_valid = 1'b0, rd_req_valid = 1'b0;
  logic       wr_req_ready, rd_req_ready;
  logic [7:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic       wr_en, rd_en, valid, rd_rsp_valid, limit_hit;
  logic [7:0] mem_addr, mem_wdata, mem_rdata = '0, rd_rsp_data;
  logic [3:0] conflict_cnt;
  logic [7:0] rom [256];
  logic [15:0] wq[$];
  logic [7:0]  rq[$], sq[$];
  byte         olog[$];
  int total = 0, bad = 0;

  rw_issuer #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .wr_en(wr_en), .rd_en(rd_en), .valid(valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .conflict_cnt(conflict_cnt), .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  // memory stub: data for a read strobe is presented the following cycle only, junk otherwise
  always @(posedge clk) mem_rdata <= rd_en ? rom[mem_addr] : 8'($urandom);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl", 32'(wr_en & rd_en), 32'h0);
      chk("strobe_valid", 32'(valid), 32'(wr_en | rd_en));
      if (!valid) chk("idle_bus", 32'({mem_addr, mem_wdata}), 32'h0);
      if (wr_en) begin
        olog.push_back(8'h57);
        if (wq.size() == 0) chk("wr_unexpected", 32'h1, 32'h0);
        else chk("wr_cmd", 32'({mem_addr, mem_wdata}), 32'(wq.pop_front()));
      end
      if (rd_en) begin
        olog.push_back(8'h52);
        if (rq.size() == 0) chk("rd_unexpected", 32'h1, 32'h0);
        else chk("rd_cmd", 32'({mem_addr, mem_wdata}), 32'({rq.pop_front(), 8'h00}));
      end
      if (rd_rsp_valid) begin
        if (sq.size() == 0) chk("rsp_unexpected", 32'h1, 32'h0);
        else chk("rsp_data", 32'(rd_rsp_data), 32'(sq.pop_front()));
      end
    end
  end

  // call at posedge+#1; returns at posedge+#1 right after the last acceptance edge
  task automatic send(input bit dw, input bit dr, input logic [7:0] wa, input logic [7:0] wd, input logic [7:0] ra);
    bit pw = dw, pr = dr, aw, ar;
    int n = 0;
    if (pw) begin wr_req_valid = 1'b1; wr_addr = wa; wr_data = wd; end
    if (pr) begin rd_req_valid = 1'b1; rd_addr = ra; end
    while ((pw || pr) && n < 60) begin
      @(negedge clk);
      n++;
      aw = pw && wr_req_ready;
      ar = pr && rd_req_ready;
      if (aw) begin wq.push_back({wa, wd}); pw = 1'b0; end
      if (ar) begin rq.push_back(ra); sq.push_back(rom[ra]); pr = 1'b0; end
      @(posedge clk);
      #1;
      if (aw) wr_req_valid = 1'b0;
      if (ar) rd_req_valid = 1'b0;
    end
    if (pw || pr) begin
      chk("accept_timeout", 32'({pw, pr}), 32'h0);
      wr_req_valid = 1'b0;
      rd_req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() + rq.size() + sq.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(wq.size() + rq.size() + sq.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_async_bus", 32'({wr_en, rd_en, valid, mem_addr, mem_wdata}), 32'h0);
    chk("rst_async_rsp", 32'({rd_rsp_valid, rd_rsp_data, conflict_cnt}), 32'h0);
    wq.delete(); rq.delete(); sq.delete(); olog.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'({wr_req_ready, rd_req_ready}), 32'h0);
      chk("rst_rsp", 32'(rd_rsp_valid), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'({wr_req_ready, rd_req_ready}), 32'h3);
    chk("post_rst_cnt", 32'({conflict_cnt, limit_hit}), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h34] = 8'h5C;
    #3;
    do_reset();

    // single write: strobe exactly two cycles after acceptance
    send(1'b1, 1'b0, 8'h12, 8'hA5, 8'h00);
    @(negedge clk);
    chk("wr_lat_n1", 32'({wr_en, rd_en, valid, wr_req_ready}), 32'h0);
    @(negedge clk);
    chk("wr_lat_n2", 32'({wr_en, rd_en, valid, mem_addr, mem_wdata}), 32'({3'b101, 8'h12, 8'hA5}));
    @(negedge clk);
    chk("wr_free", 32'({wr_en, wr_req_ready}), 32'h1);
    drain();

    // single read: strobe at N+2, response only at N+4
    send(1'b0, 1'b1, 8'h00, 8'h00, 8'h34);
    @(negedge clk);
    chk("rd_lat_n1", 32'({rd_en, rd_rsp_valid}), 32'h0);
    @(negedge clk);
    chk("rd_lat_n2", 32'({wr_en, rd_en, valid, mem_addr, mem_wdata}), 32'({3'b011, 8'h34, 8'h00}));
    @(negedge clk);
    chk("rd_lat_n3", 32'({valid, rd_rsp_valid, rd_req_ready}), 32'h1);
    @(negedge clk);
    chk("rd_lat_n4", 32'({rd_rsp_valid, rd_rsp_data}), 32'({1'b1, 8'h5C}));
    @(negedge clk);
    chk("rd_lat_n5", 32'(rd_rsp_valid), 32'h0);
    drain();

    // simultaneous after reset: write wins, one conflict
    do_reset();
    send(1'b1, 1'b1, 8'h21, 8'h3C, 8'h77);
    drain();
    chk("dual_order_len", 32'(olog.size()), 32'h2);
    if (olog.size() == 2) chk("dual_order", 32'({olog[0], olog[1]}), 32'h5752);
    chk("dual_cnt", 32'(conflict_cnt), 32'h1);

    // write alone moves favour to reads, so the next conflict grants the read
    do_reset();
    send(1'b1, 1'b0, 8'h01, 8'h02, 8'h00);
    drain();
    send(1'b1, 1'b1, 8'h03, 8'h04, 8'h05);
    drain();
    chk("rr_order_len", 32'(olog.size()), 32'h3);
    if (olog.size() == 3) chk("rr_order", 32'({olog[0], olog[1], olog[2]}), 32'h575257);

    // 20 dual rounds: strict alternation, count saturates at 15
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      int exp_cnt;
      send(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      drain();
      exp_cnt = (k > 15) ? 15 : k;
      chk("sat_cnt", 32'(conflict_cnt), 32'(exp_cnt));
      chk("sat_limit", 32'(limit_hit), 32'(exp_cnt >= 14));
    end
    chk("alt_len", 32'(olog.size()), 32'd40);
    for (int i = 0; i < olog.size(); i++) chk("alt_order", 32'(olog[i]), (i % 2 == 0) ? 32'h57 : 32'h52);

    // reset during RD: bus clears immediately, response dropped, next write completes
    do_reset();
    send(1'b0, 1'b1, 8'h00, 8'h00, 8'h44);
    @(negedge clk);
    @(negedge clk);
    chk("rd_before_rst", 32'(rd_en), 32'h1);
    #1;
    do_reset();
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(rd_rsp_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 8'h9E, 8'h6B, 8'h00);
    drain();
    chk("post_rst_wr", 32'(olog.size()), 32'h1);

    // randomized independent traffic on both channels
    do_reset();
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'h00);
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send(1'b0, 1'b1, 8'h00, 8'h00, 8'($urandom));
      end
    join
    drain();
    chk("rand_strobes", 32'(olog.size()), 32'd80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/rw_issuer.md
RW_ISSUER -- requirements
Module: rw_issuer

Interface
REQ-001 Parameter AW, default 8, address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_req_valid  input  1  write request offered.
REQ-006 wr_req_ready  output  1  write holding register empty.
REQ-007 wr_addr  input  AW  write address.
REQ-008 wr_data  input  DW  write data.
REQ-009 rd_req_valid  input  1  read request offered.
REQ-010 rd_req_ready  output  1  read holding register empty.
REQ-011 rd_addr  input  AW  read address.
REQ-012 wr_en  output  1  memory write strobe.
REQ-013 rd_en  output  1  memory read strobe.
REQ-014 valid  output  1  memory command valid.
REQ-015 mem_addr  output  AW  memory address.
REQ-016 mem_wdata  output  DW  memory write data.
REQ-017 mem_rdata  input  DW  memory read data, valid the cycle after rd_en.
REQ-018 rd_rsp_valid  output  1  one-cycle read response pulse.
REQ-019 rd_rsp_data  output  DW  read response data.
REQ-020 conflict_cnt  output  4  saturating count of arbitration conflicts.
REQ-021 limit_hit  output  1  conflict_cnt >= 14.

Function
REQ-022 A request SHALL be accepted on a rising edge where valid && ready; the addr/data are captured into that channel's single-entry holding register, and ready SHALL be low from the next cycle until the entry issues.
REQ-023 FSM states SHALL be IDLE, WR, RD and RDLAT; all memory-side outputs are decoded from registered state.
REQ-024 IDLE: no entry pending -> stay IDLE; only write pending -> WR; only read pending -> RD; both pending -> grant per rr_ptr.
REQ-025 rr_ptr SHALL be 0 (favour write) or 1 (favour read), and SHALL toggle to the non-granted side on every grant, including single-requester grants.
REQ-026 WR SHALL last exactly one cycle: wr_en=1, rd_en=0, valid=1, mem_addr/mem_wdata from the write entry; the entry frees at the end of the cycle; next state is IDLE.
REQ-027 RD SHALL last exactly one cycle: rd_en=1, wr_en=0, valid=1, mem_addr from the read entry, mem_wdata=0; the entry frees; next state is RDLAT.
REQ-028 RDLAT SHALL last one cycle with valid=wr_en=rd_en=0; mem_rdata is sampled at its end, and rd_rsp_valid=1 with that data SHALL follow for exactly the next cycle.
REQ-029 In IDLE and RDLAT, wr_en=rd_en=valid=0 and mem_addr=mem_wdata=0.
REQ-030 wr_en && rd_en SHALL never be 1 in the same cycle; wr_en or rd_en SHALL never be 1 without valid=1.
REQ-031 Latency: a request accepted at edge N into an empty, IDLE block SHALL drive its strobe in cycle N+2; a read response SHALL appear in cycle N+4.
REQ-032 A freed entry SHALL raise ready the cycle after WR/RD, so a new request can be accepted the same cycle the FSM returns to IDLE.
REQ-033 conflict_cnt SHALL increment by 1 on each IDLE decision with both entries pending, and SHALL saturate at 15 (no wrap).
REQ-034 limit_hit SHALL be combinational from conflict_cnt (1 at 14 and 15).

Reset
REQ-035 When rst_n=0, the block SHALL immediately (asynchronously) force: state=IDLE, both entries empty, rr_ptr=0, wr_en=rd_en=valid=0, mem_addr=mem_wdata=0, rd_rsp_valid=0, rd_rsp_data=0, conflict_cnt=0.
REQ-036 While rst_n=0, wr_req_ready=rd_req_ready=0; both SHALL be 1 from the first edge after deassertion.
REQ-037 A reset during WR, RD or RDLAT SHALL drop the in-flight operation; no rd_rsp_valid pulse SHALL be produced for it.

Verification
REQ-038 Single write: wr addr=0x12, data=0xA5 accepted at edge N -> cycle N+2 shows wr_en=1, valid=1, mem_addr=0x12, mem_wdata=0xA5; rd_en=0.
REQ-039 Single read: rd addr=0x34, memory returns 0x5C -> rd_en in N+2; rd_rsp_valid=1 with rd_rsp_data=0x5C in N+4 only.
REQ-040 Simultaneous requests after reset -> write issues first, then read; conflict_cnt=1; wr_en and rd_en are never both high.
REQ-041 20 back-to-back dual requests -> order strictly alternates; conflict_cnt reaches 14 (limit_hit=1), then saturates at 15.
REQ-042 rst_n pulled low during RD -> all outputs 0 at once; no response pulse; after release the first write completes normally.
REQ-043 Continuous assertion over all tests: !(wr_en && rd_en), and (wr_en || rd_en) implies valid.
